// File: rtl/fifo_pkg.sv
// Shared types and helpers for the wide-write / narrow-read FIFO.
package fifo_pkg;

  typedef enum logic {
    SliceMsbFirst,
    SliceLsbFirst
  } slice_order_e;

  // Level counts narrow slices: up to 2**aw * ratio, hence the extra bit.
  function automatic int unsigned level_width(input int unsigned aw, input int unsigned ratio);
    return aw + $clog2(ratio) + 1;
  endfunction

  // Modular difference of two width-bit pointers.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
    return (a - b) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_width_conv_if.sv
// Handshake bundle for fifo_width_conv; FIFO_ERR_FLAGS_EN adds overflow/underflow.
interface fifo_width_conv_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RATIO         = 2,
  parameter int unsigned ADDRESS_WIDTH = 4
);
  localparam int unsigned LevelW = level_width(ADDRESS_WIDTH, RATIO);

  logic                        write;
  logic [RATIO*DATA_WIDTH-1:0] w_data;
  logic                        read;
  logic [DATA_WIDTH-1:0]       r_data;
  logic                        full_flag;
  logic                        empty_flag;
  logic                        almost_full;
  logic                        almost_empty;
  logic [LevelW-1:0]           level;
`ifdef FIFO_ERR_FLAGS_EN
  logic                        overflow;
  logic                        underflow;

  modport master (
    output write, w_data, read,
    input  r_data, full_flag, empty_flag, almost_full, almost_empty, level, overflow, underflow
  );
  modport slave (
    input  write, w_data, read,
    output r_data, full_flag, empty_flag, almost_full, almost_empty, level, overflow, underflow
  );
`else
  modport master (
    output write, w_data, read,
    input  r_data, full_flag, empty_flag, almost_full, almost_empty, level
  );
  modport slave (
    input  write, w_data, read,
    output r_data, full_flag, empty_flag, almost_full, almost_empty, level
  );
`endif

endinterface

// File: rtl/fifo_conv_ctrl.sv
// Pointer, slice index, flag and level bookkeeping for fifo_width_conv.
// FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_conv_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned RATIO         = 2,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned AF_THRESH     = 1,
  parameter int unsigned AE_THRESH     = 1,
  localparam int unsigned SubW   = $clog2(RATIO),
  localparam int unsigned LevelW = level_width(ADDRESS_WIDTH, RATIO)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     write_i,
  input  logic                     read_i,
  output logic                     w_en_o,
  output logic [ADDRESS_WIDTH-1:0] w_addr_o,
  output logic [ADDRESS_WIDTH-1:0] r_addr_o,
  output logic [SubW-1:0]          sub_idx_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                     overflow_o,
  output logic                     underflow_o,
`endif
  output logic [LevelW-1:0]        level_o
);
  localparam int unsigned PtrW  = ADDRESS_WIDTH + 1;
  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
  localparam logic [SubW-1:0] SubLast = SubW'(RATIO - 1);

  logic [PtrW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, words_used;
  logic [SubW-1:0] sub_idx_q, sub_idx_d;
  logic            w_acc, r_acc;

  assign empty_o = (w_ptr_q == r_ptr_q);
  assign full_o  = (w_ptr_q[ADDRESS_WIDTH-1:0] == r_ptr_q[ADDRESS_WIDTH-1:0]) &&
                   (w_ptr_q[ADDRESS_WIDTH] != r_ptr_q[ADDRESS_WIDTH]);

  // Acceptance uses registered flags only, so a read never frees a slot for a same-cycle write.
  assign w_acc = write_i & ~full_o;
  assign r_acc = read_i & ~empty_o;

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    sub_idx_d = sub_idx_q;
    if (w_acc) w_ptr_d = w_ptr_q + PtrW'(1);
    if (r_acc) begin
      if (sub_idx_q == SubLast) begin
        sub_idx_d = '0;
        r_ptr_d   = r_ptr_q + PtrW'(1);
      end else begin
        sub_idx_d = sub_idx_q + SubW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      sub_idx_q <= '0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      sub_idx_q <= sub_idx_d;
    end
  end

  assign words_used     = PtrW'(ptr_diff(32'(w_ptr_q), 32'(r_ptr_q), PtrW));
  assign level_o        = {words_used, {SubW{1'b0}}} - LevelW'(sub_idx_q);
  assign almost_full_o  = (Depth - 32'(words_used)) <= AF_THRESH;
  assign almost_empty_o = 32'(level_o) <= AE_THRESH;

  assign w_en_o    = w_acc;
  assign w_addr_o  = w_ptr_q[ADDRESS_WIDTH-1:0];
  assign r_addr_o  = r_ptr_q[ADDRESS_WIDTH-1:0];
  assign sub_idx_o = sub_idx_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write_i & full_o)  overflow_q  <= 1'b1;
      if (read_i  & empty_o) underflow_q <= 1'b1;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule

// File: rtl/fifo_width_conv.sv
// Wide-write / narrow-read FWFT FIFO: storage array and head slice mux.
// FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags on the interface.
module fifo_width_conv
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RATIO         = 2,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned LSB_FIRST     = 1,
  parameter int unsigned AF_THRESH     = 1,
  parameter int unsigned AE_THRESH     = 1
) (
  input logic              clk,
  input logic              reset,
  fifo_width_conv_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDRESS_WIDTH;
  localparam int unsigned SubW  = $clog2(RATIO);
  localparam slice_order_e Order = (LSB_FIRST != 0) ? SliceLsbFirst : SliceMsbFirst;

  logic [RATIO-1:0][DATA_WIDTH-1:0] mem [Depth];
  logic [RATIO-1:0][DATA_WIDTH-1:0] head;
  logic                             w_en;
  logic [ADDRESS_WIDTH-1:0]         w_addr, r_addr;
  logic [SubW-1:0]                  sub_idx, slice_sel;

  fifo_conv_ctrl #(
    .RATIO         (RATIO),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .AF_THRESH     (AF_THRESH),
    .AE_THRESH     (AE_THRESH)
  ) u_ctrl (
    .clk_i          (clk),
    .reset_i        (reset),
    .write_i        (bus.write),
    .read_i         (bus.read),
    .w_en_o         (w_en),
    .w_addr_o       (w_addr),
    .r_addr_o       (r_addr),
    .sub_idx_o      (sub_idx),
    .full_o         (bus.full_flag),
    .empty_o        (bus.empty_flag),
    .almost_full_o  (bus.almost_full),
    .almost_empty_o (bus.almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow_o     (bus.overflow),
    .underflow_o    (bus.underflow),
`endif
    .level_o        (bus.level)
  );

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= bus.w_data;
  end

  assign head = mem[r_addr];

  // RATIO is a power of two, so RATIO-1-sub_idx is the bitwise complement.
  assign slice_sel  = (Order == SliceLsbFirst) ? sub_idx : ~sub_idx;
  assign bus.r_data = bus.empty_flag ? '0 : head[slice_sel];

endmodule

// File: doc/fifo_width_conv.md
Name: fifo_width_conv

Overview:
Parametrised wide-write / narrow-read circular-queue FIFO with first-word-fall-through on the read side. Each write pushes one word of RATIO*DATA_WIDTH bits; each read pops one DATA_WIDTH slice. Slice order is selectable, and the FIFO reports occupancy in narrow units plus almost-full/almost-empty thresholds. It sits between wide producers (bus, DMA) and byte-serial consumers (UART TX, SPI).

Parameters:
DATA_WIDTH, 8, narrow (read) word width in bits
RATIO, 2, narrow slices per wide word; power of 2, >=2
ADDRESS_WIDTH, 4, log2 of storage depth in wide words
LSB_FIRST, 1, 1: slice 0 = bits [DATA_WIDTH-1:0] read first; 0: MS slice read first
AF_THRESH, 1, almost_full asserts when free wide slots <= AF_THRESH
AE_THRESH, 1, almost_empty asserts when level (narrow units) <= AE_THRESH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
write  in  1  push request
w_data  in  RATIO*DATA_WIDTH  wide write word
read  in  1  pop request (one narrow slice)
r_data  out  DATA_WIDTH  current head slice (FWFT)
full_flag  out  1  no free wide slot
empty_flag  out  1  no unread slice
almost_full  out  1  threshold flag
almost_empty  out  1  threshold flag
level  out  ADDRESS_WIDTH+$clog2(RATIO)+1  unread narrow slices

Behaviour:
- Storage: 2**ADDRESS_WIDTH wide words; memory is not reset.
- Pointers w_ptr and r_ptr are ADDRESS_WIDTH+1 bits (wrap bit). sub_idx is $clog2(RATIO) bits.
- empty_flag = (w_ptr == r_ptr).
- full_flag = (address bits equal) and (wrap bits differ).
- Flags, level and thresholds are combinational from registered state only; they never depend on same-cycle write/read.
- Write accepted iff write & ~full_flag: mem[w_ptr] <= w_data, then w_ptr++. A rejected write is dropped silently.
- Read accepted iff read & ~empty_flag:
  - if sub_idx == RATIO-1: sub_idx <= 0 and r_ptr++ (frees the wide slot);
  - else: sub_idx++.
- r_data selects the slice of mem[r_ptr] indexed by sub_idx (LSB_FIRST=1), or by RATIO-1-sub_idx (LSB_FIRST=0). It is valid combinationally with zero read latency. It is forced to 0 while empty_flag=1.
- A written word becomes visible on r_data the cycle after the write edge.
- level = (w_ptr - r_ptr)*RATIO - sub_idx, using modular pointer subtraction.
- almost_full = (2**ADDRESS_WIDTH - words_used) <= AF_THRESH.
- almost_empty = level <= AE_THRESH.
- Simultaneous write and read:
  - neither full nor empty: both accepted;
  - full: only the read is accepted, and the write is rejected even if this read frees a slot;
  - empty: only the write is accepted.
- Pointer wrap at 2**ADDRESS_WIDTH is natural binary rollover.
- Reset (asserted at any time, including mid-word): w_ptr=r_ptr=0, sub_idx=0. Outputs: empty_flag=1, full_flag=0, almost_empty=1, almost_full=0 (given AF_THRESH < depth), level=0, r_data=0. A partially read word is discarded.

Optional Feature:
FIFO_ERR_FLAGS_EN
- Defined: adds outputs overflow (1 bit) and underflow (1 bit).
  - overflow sets on write & full_flag.
  - underflow sets on read & empty_flag.
  - Both are sticky until reset; reset value 0.
- Undefined: ports absent; rejected accesses are ignored silently.

Decomposition:
- Package fifo_pkg: typedef of slice-order enum (LSB_FIRST/MSB_FIRST); function for level width; function for pointer difference.
- Sub-module fifo_conv_ctrl: pointers, sub_idx, flags, level and thresholds.
- Top level: storage array and slice mux.

Test Plan (DATA_WIDTH=8, RATIO=2, ADDRESS_WIDTH=2, LSB_FIRST=1, AF=1, AE=1):
1. Reset, then write 16'hA1B2 -> next cycle empty_flag=0, r_data=8'hB2, level=2. Read -> r_data=8'hA1, level=1. Read -> empty_flag=1, r_data=0.
2. Write 4 words 16'h0100..16'h0403 -> full_flag=1, level=8, almost_full=1. A 5th write 16'hFFFF is dropped. Reading 8 slices yields 00,01,01,02,02,03,03,04.
3. Full FIFO, assert read and write 16'h5555 in the same cycle, with sub_idx=1 -> write rejected, full_flag=0 next cycle, level=6.
4. Wrap: 6 writes interleaved with 12 reads -> data order preserved across the pointer rollover; final state empty.
5. LSB_FIRST=0: write 16'hA1B2 -> reads yield A1 then B2.
6. Assert reset after 1 of 2 slices has been read -> level=0, empty_flag=1, sub_idx=0. A new write 16'hC3D4 reads D4 first. With FIFO_ERR_FLAGS_EN defined, a read while empty sets underflow=1, which stays set until reset.
